// File: rtl/hilo_unit.sv
`default_nettype none
// ============================================================================
// hilo_unit : MIPS HI/LO execute unit - MTHI/MTLO/MFHI/MFLO, single-cycle
//             MULT/MULTU and an iterative restoring DIV/DIVU with stall.
// Revision  : 1.0
// ============================================================================
module hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic             flush,
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [WIDTH-1:0] mf_data,
  output logic             stall,
  output logic [1:0]       hilo_we,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int         c_CW    = $clog2(WIDTH + 1);
  localparam logic [5:0] c_MFHI  = 6'b010000;
  localparam logic [5:0] c_MTHI  = 6'b010001;
  localparam logic [5:0] c_MFLO  = 6'b010010;
  localparam logic [5:0] c_MTLO  = 6'b010011;
  localparam logic [5:0] c_MULT  = 6'b011000;
  localparam logic [5:0] c_MULTU = 6'b011001;
  localparam logic [5:0] c_DIV   = 6'b011010;
  localparam logic [5:0] c_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state, w_state_next;

  logic [WIDTH-1:0] r_hi, r_lo;
  logic [WIDTH-1:0] r_rem, r_quo, r_dvs;
  logic [c_CW-1:0]  r_cnt;
  logic             r_qneg, r_rneg, r_dzero;

  // ---------------------------------------------------------------- decode
  logic [5:0] w_funct;
  logic       w_special, w_is_mfhi, w_is_mflo, w_is_mthi, w_is_mtlo;
  logic       w_is_mult, w_is_div, w_op_signed, w_accept;
  logic       w_unused;

  assign w_funct     = instr[5:0];
  assign w_special   = (instr[31:26] == 6'b000000);
  assign w_is_mfhi   = w_special && (w_funct == c_MFHI);
  assign w_is_mflo   = w_special && (w_funct == c_MFLO);
  assign w_is_mthi   = w_special && (w_funct == c_MTHI);
  assign w_is_mtlo   = w_special && (w_funct == c_MTLO);
  assign w_is_mult   = w_special && ((w_funct == c_MULT) || (w_funct == c_MULTU));
  assign w_is_div    = w_special && ((w_funct == c_DIV) || (w_funct == c_DIVU));
  assign w_op_signed = ~w_funct[0];
  assign w_unused    = ^instr[25:6];

  // rst gates acceptance so every output reads 0 while reset is held
  assign w_accept = valid && !flush && !rst && (r_state == S_IDLE);

  // --------------------------------------------------------------- multiply
  logic [2*WIDTH-1:0] w_mul_a, w_mul_b, w_prod;

  assign w_mul_a = w_op_signed ? {{WIDTH{rs_val[WIDTH-1]}}, rs_val} : {{WIDTH{1'b0}}, rs_val};
  assign w_mul_b = w_op_signed ? {{WIDTH{rt_val[WIDTH-1]}}, rt_val} : {{WIDTH{1'b0}}, rt_val};
  assign w_prod  = w_mul_a * w_mul_b;

  // ---------------------------------------------------------------- divider
  logic             w_rs_neg, w_rt_neg, w_qbit;
  logic [WIDTH-1:0] w_rs_mag, w_rt_mag, w_rem_next, w_quo_fix, w_rem_fix;
  logic [WIDTH:0]   w_rem_sh, w_trial;

  assign w_rs_neg = w_op_signed & rs_val[WIDTH-1];
  assign w_rt_neg = w_op_signed & rt_val[WIDTH-1];
  assign w_rs_mag = w_rs_neg ? -rs_val : rs_val;
  assign w_rt_mag = w_rt_neg ? -rt_val : rt_val;

  assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
  assign w_trial    = w_rem_sh - {1'b0, r_dvs};
  assign w_qbit     = ~w_trial[WIDTH];
  assign w_rem_next = w_qbit ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];

  // With a zero divisor the remainder ends as |rs|; re-applying rs's sign
  // returns the original rs_val bit pattern, so HI needs no special case.
  assign w_quo_fix = r_dzero ? {WIDTH{1'b1}} : (r_qneg ? -r_quo : r_quo);
  assign w_rem_fix = r_rneg ? -r_rem : r_rem;

  // ------------------------------------------------------- FSM / write ctrl
  logic [WIDTH-1:0] w_hi_d, w_lo_d;

  always_comb begin
    w_state_next = r_state;
    stall        = 1'b0;
    hilo_we      = 2'b00;
    w_hi_d       = r_hi;
    w_lo_d       = r_lo;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_is_mthi) begin
            hilo_we = 2'b10;
            w_hi_d  = rs_val;
          end else if (w_is_mtlo) begin
            hilo_we = 2'b01;
            w_lo_d  = rs_val;
          end else if (w_is_mult) begin
            hilo_we = 2'b11;
            w_hi_d  = w_prod[2*WIDTH-1:WIDTH];
            w_lo_d  = w_prod[WIDTH-1:0];
          end else if (w_is_div) begin
            stall        = 1'b1;
            w_state_next = S_RUN;
          end
        end
      end
      S_RUN: begin
        stall = 1'b1;
        if (flush) begin
          w_state_next = S_IDLE;
        end else if (r_cnt == c_CW'(1)) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        hilo_we      = 2'b11;
        w_hi_d       = w_rem_fix;
        w_lo_d       = w_quo_fix;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign mf_data = w_is_mfhi ? r_hi : (w_is_mflo ? r_lo : '0);
  assign hi_o    = r_hi;
  assign lo_o    = r_lo;

  // --------------------------------------------------------------- registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (hilo_we[1]) r_hi <= w_hi_d;
      if (hilo_we[0]) r_lo <= w_lo_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
      r_dzero <= 1'b0;
    end else if (w_accept && w_is_div) begin
      r_rem   <= '0;
      r_quo   <= w_rs_mag;
      r_dvs   <= w_rt_mag;
      r_cnt   <= c_CW'(WIDTH);
      r_qneg  <= w_rs_neg ^ w_rt_neg;
      r_rneg  <= w_rs_neg;
      r_dzero <= (rt_val == '0);
    end else if ((r_state == S_RUN) && !flush) begin
      r_rem <= w_rem_next;
      r_quo <= {r_quo[WIDTH-2:0], w_qbit};
      r_cnt <= r_cnt - c_CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hilo_unit.sv
`default_nettype none
// tb_hilo_unit : vector table, directed multi-cycle sequences and randomized
// operations compared against an arithmetic reference model of HI/LO.
module tb_hilo_unit;

  localparam int W = 32;
  localparam int DIV_STALLS = W + 1;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic          clk = 1'b0;
  logic          rst, valid, flush;
  logic [31:0]   instr;
  logic [W-1:0]  rs_val, rt_val, mf_data, hi_o, lo_o;
  logic          stall;
  logic [1:0]    hilo_we;

  always #5 clk = ~clk;

  hilo_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .valid(valid), .flush(flush), .instr(instr),
    .rs_val(rs_val), .rt_val(rt_val), .mf_data(mf_data), .stall(stall),
    .hilo_we(hilo_we), .hi_o(hi_o), .lo_o(lo_o)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi, m_lo;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [5:0] fn);
    return {op, 20'h0, fn};
  endfunction

  function automatic logic is_div_ins(input logic [31:0] ins);
    return (ins[31:26] == 6'd0) && (ins[5:0] == F_DIV || ins[5:0] == F_DIVU);
  endfunction

  // Reference: returns {we, new_hi, new_lo} from plain integer arithmetic.
  function automatic logic [65:0] model(input logic [31:0] ins, rs, rt, hi, lo, input logic acc);
    logic [1:0]  we = 2'b00;
    logic [31:0] nh = hi;
    logic [31:0] nl = lo;
    logic [63:0] p;
    longint a, b, q, r;
    if (acc && ins[31:26] == 6'd0) begin
      case (ins[5:0])
        F_MTHI: begin we = 2'b10; nh = rs; end
        F_MTLO: begin we = 2'b01; nl = rs; end
        F_MULT: begin
          p  = longint'($signed(rs)) * longint'($signed(rt));
          we = 2'b11; nh = p[63:32]; nl = p[31:0];
        end
        F_MULTU: begin
          p  = {32'd0, rs} * {32'd0, rt};
          we = 2'b11; nh = p[63:32]; nl = p[31:0];
        end
        F_DIV, F_DIVU: begin
          we = 2'b11;
          if (rt == 32'd0) begin
            nl = 32'hFFFF_FFFF; nh = rs;
          end else if (ins[5:0] == F_DIVU) begin
            nl = rs / rt; nh = rs % rt;
          end else begin
            a = longint'($signed(rs)); b = longint'($signed(rt));
            q = a / b; r = a % b;
            nl = q[31:0]; nh = r[31:0];
          end
        end
        default: ;
      endcase
    end
    return {we, nh, nl};
  endfunction

  function automatic logic [31:0] mf_model(input logic [31:0] ins, hi, lo);
    if (ins[31:26] != 6'd0) return 32'd0;
    if (ins[5:0] == F_MFHI) return hi;
    if (ins[5:0] == F_MFLO) return lo;
    return 32'd0;
  endfunction

  // Presents one instruction from cycle 0 until it stops stalling; flush
  // applies only in cycle 0. Returns hilo_we of the completing cycle.
  task automatic exec_op(input logic [31:0] ins, rs, rt, input logic v, f,
                         output logic [1:0] we, output logic [31:0] mf, output int stalls);
    bit done = 0;
    instr = ins; rs_val = rs; rt_val = rt; valid = v; flush = f;
    stalls = 0; we = 2'b00; mf = 32'd0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (c == 0) mf = mf_data;
      if (stall) begin
        stalls++;
        @(posedge clk); #1;
        flush = 1'b0;
      end else begin
        we = hilo_we;
        done = 1;
      end
    end
    if (!done) check("op_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    valid = 1'b0; flush = 1'b0;
  endtask

  typedef struct {
    logic [31:0] ins, rs, rt, hi, lo, mf;
    logic [1:0]  we;
    int          stalls;
  } vec_t;

  vec_t tbl[15];

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  we;
    logic [31:0] mf;
    int          st;
    logic [65:0] res;
    bit          hit;

    tbl[0]  = '{mk(0, F_MTHI),  32'h12345678, 32'h0,        32'h12345678, 32'h0,        32'h0,        2'b10, 0};
    tbl[1]  = '{mk(0, F_MTLO),  32'h9ABCDEF0, 32'h0,        32'h12345678, 32'h9ABCDEF0, 32'h0,        2'b01, 0};
    tbl[2]  = '{mk(0, F_MFHI),  32'h0,        32'h0,        32'h12345678, 32'h9ABCDEF0, 32'h12345678, 2'b00, 0};
    tbl[3]  = '{mk(0, F_MFLO),  32'h0,        32'h0,        32'h12345678, 32'h9ABCDEF0, 32'h9ABCDEF0, 2'b00, 0};
    tbl[4]  = '{mk(0, F_MULT),  32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF, 32'hFFFFFFFA, 32'h0,        2'b11, 0};
    tbl[5]  = '{mk(0, F_MULTU), 32'hFFFFFFFE, 32'h3,        32'h00000002, 32'hFFFFFFFA, 32'h0,        2'b11, 0};
    tbl[6]  = '{mk(0, F_DIV),   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 32'h0,        2'b11, DIV_STALLS};
    tbl[7]  = '{mk(0, F_DIVU),  32'd100,      32'd7,        32'd2,        32'd14,       32'h0,        2'b11, DIV_STALLS};
    tbl[8]  = '{mk(0, F_DIVU),  32'h55,       32'h0,        32'h55,       32'hFFFFFFFF, 32'h0,        2'b11, DIV_STALLS};
    tbl[9]  = '{mk(0, F_DIV),   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 32'h0,        2'b11, DIV_STALLS};
    tbl[10] = '{mk(6'h23, F_MTHI), 32'hDEADBEEF, 32'h0,     32'h0,        32'h80000000, 32'h0,        2'b00, 0};
    tbl[11] = '{mk(0, 6'b100000), 32'hDEADBEEF, 32'h1,      32'h0,        32'h80000000, 32'h0,        2'b00, 0};
    tbl[12] = '{mk(0, F_MFLO),  32'h0,        32'h0,        32'h0,        32'h80000000, 32'h80000000, 2'b00, 0};
    tbl[13] = '{mk(0, F_DIV),   32'd100,      32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 32'h0,        2'b11, DIV_STALLS};
    tbl[14] = '{mk(0, F_DIV),   32'hFFFFFFF0, 32'h0,        32'hFFFFFFF0, 32'hFFFFFFFF, 32'h0,        2'b11, DIV_STALLS};

    // reset state, with a valid DIV presented while reset is held
    rst = 1'b1; valid = 1'b1; flush = 1'b0; instr = mk(0, F_DIV);
    rs_val = 32'd9; rt_val = 32'd2;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", hi_o, 0);
    check("rst_lo", lo_o, 0);
    check("rst_stall", stall, 0);
    check("rst_we", hilo_we, 0);
    instr = mk(0, F_MFHI); #1;
    check("rst_mf", mf_data, 0);
    valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      exec_op(tbl[i].ins, tbl[i].rs, tbl[i].rt, 1'b1, 1'b0, we, mf, st);
      check($sformatf("vec%0d_we", i), we, tbl[i].we);
      check($sformatf("vec%0d_mf", i), mf, tbl[i].mf);
      check($sformatf("vec%0d_stall", i), st, tbl[i].stalls);
      check($sformatf("vec%0d_hi", i), hi_o, tbl[i].hi);
      check($sformatf("vec%0d_lo", i), lo_o, tbl[i].lo);
    end
    m_hi = 32'hFFFFFFF0; m_lo = 32'hFFFFFFFF;

    // flush while RUN with cnt=10: abort, HI/LO untouched, next MTLO accepted
    exec_op(mk(0, F_MTHI), 32'hAAAA5555, 0, 1'b1, 1'b0, we, mf, st);
    exec_op(mk(0, F_MTLO), 32'h5555AAAA, 0, 1'b1, 1'b0, we, mf, st);
    instr = mk(0, F_DIV); rs_val = 32'd1000; rt_val = 32'd3; valid = 1'b1; flush = 1'b0;
    @(posedge clk); #1;
    repeat (W - 10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    check("flushrun_stall", stall, 1);
    check("flushrun_we", hilo_we, 0);
    @(posedge clk); #1;
    flush = 1'b0; instr = mk(0, F_MTLO); rs_val = 32'h0F0F0F0F;
    check("flushrun_hi", hi_o, 32'hAAAA5555);
    check("flushrun_lo", lo_o, 32'h5555AAAA);
    @(negedge clk);
    check("postflush_stall", stall, 0);
    check("postflush_we", hilo_we, 2'b01);
    @(posedge clk); #1;
    valid = 1'b0;
    check("postflush_lo", lo_o, 32'h0F0F0F0F);
    check("postflush_hi", hi_o, 32'hAAAA5555);

    // flush during DONE must not block the write
    instr = mk(0, F_DIVU); rs_val = 32'd100; rt_val = 32'd7; valid = 1'b1;
    hit = 0;
    for (int c = 0; c < 60 && !hit; c++) begin
      @(negedge clk);
      if (!stall && c > 0) hit = 1;
      else begin @(posedge clk); #1; end
    end
    check("done_reached", hit, 1);
    flush = 1'b1; #1;
    check("flushdone_we", hilo_we, 2'b11);
    @(posedge clk); #1;
    valid = 1'b0; flush = 1'b0;
    check("flushdone_hi", hi_o, 32'd2);
    check("flushdone_lo", lo_o, 32'd14);
    m_hi = 32'd2; m_lo = 32'd14;

    // randomized operations against the reference model
    for (int n = 0; n < 150; n++) begin
      logic [5:0]  fset [9];
      logic [31:0] ops  [2];
      logic [31:0] rnd, ins;
      logic [5:0]  op;
      logic        v, f, acc;
      fset = '{F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU, 6'b100001};
      for (int k = 0; k < 2; k++) begin
        case ($urandom_range(0, 5))
          0: ops[k] = 32'd0;
          1: ops[k] = 32'hFFFFFFFF;
          2: ops[k] = 32'h80000000;
          3: ops[k] = $urandom_range(0, 20);
          default: ops[k] = $urandom();
        endcase
      end
      rnd = $urandom();
      op  = ($urandom_range(0, 15) == 0) ? 6'h04 : 6'h00;
      ins = {op, rnd[19:0], fset[$urandom_range(0, 8)]};
      v   = ($urandom_range(0, 9) != 0);
      f   = ($urandom_range(0, 9) == 0);
      acc = v && !f;
      res = model(ins, ops[0], ops[1], m_hi, m_lo, acc);
      exec_op(ins, ops[0], ops[1], v, f, we, mf, st);
      check($sformatf("rnd%0d_we ins=%h", n, ins), we, res[65:64]);
      check($sformatf("rnd%0d_mf", n), mf, mf_model(ins, m_hi, m_lo));
      check($sformatf("rnd%0d_stall", n), st, (acc && is_div_ins(ins)) ? DIV_STALLS : 0);
      check($sformatf("rnd%0d_hi rs=%h rt=%h", n, ops[0], ops[1]), hi_o, res[63:32]);
      check($sformatf("rnd%0d_lo rs=%h rt=%h", n, ops[0], ops[1]), lo_o, res[31:0]);
      m_hi = res[63:32]; m_lo = res[31:0];
    end

    // asynchronous reset in the middle of a divide
    exec_op(mk(0, F_MTHI), 32'hDEADBEEF, 0, 1'b1, 1'b0, we, mf, st);
    instr = mk(0, F_DIV); rs_val = 32'd12345; rt_val = 32'd17; valid = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    check("middiv_stall", stall, 1);
    rst = 1'b1; #1;
    check("asyncrst_stall", stall, 0);
    check("asyncrst_we", hilo_we, 0);
    check("asyncrst_hi", hi_o, 0);
    check("asyncrst_lo", lo_o, 0);
    valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    exec_op(mk(0, F_MTLO), 32'h00C0FFEE, 0, 1'b1, 1'b0, we, mf, st);
    check("postrst_we", we, 2'b01);
    check("postrst_lo", lo_o, 32'h00C0FFEE);
    check("postrst_hi", hi_o, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
